// File: rtl/gain_ramp_ctrl.sv
// Gain ramp controller: latches gain targets over valid/ready and slews the applied gain
// by at most RAMP_STEP LSBs per sample tick. Soft mute is built only with GAIN_RAMP_SOFT_MUTE_EN.
module gain_ramp_ctrl #(
   parameter int GAIN_WIDTH   = 11,
   parameter int DEFAULT_GAIN = 16,
   parameter int RAMP_STEP    = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_sample_tick,
   input  logic                  i_set_valid,
   input  logic [GAIN_WIDTH-1:0] i_set_gain,
   output logic                  o_set_ready,
   input  logic                  i_mute,
   output logic [GAIN_WIDTH-1:0] o_gain_value,
   output logic                  o_pipe_valid,
   output logic                  o_busy
);

   // state   | meaning
   // S_IDLE  | gain settled on target, new target accepted
   // S_RAMP  | stepping gain toward effective target on each sample tick
   // S_MUTED | gain held at zero, targets latched but not applied
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RAMP = 2'd1
`ifdef GAIN_RAMP_SOFT_MUTE_EN
      ,
      S_MUTED = 2'd2
`endif
   } state_t;

   localparam logic [GAIN_WIDTH-1:0] C_DEFAULT = GAIN_WIDTH'(DEFAULT_GAIN);
   localparam logic [GAIN_WIDTH-1:0] C_STEP    = GAIN_WIDTH'(RAMP_STEP);

   state_t                r_state;
   logic [GAIN_WIDTH-1:0] r_cur;
   logic [GAIN_WIDTH-1:0] r_tgt;
   logic                  r_pipe_valid;
   logic                  r_set_ready;
   logic                  r_busy;

   state_t                w_state_nxt;
   logic [GAIN_WIDTH-1:0] w_cur_nxt;
   logic [GAIN_WIDTH-1:0] w_tgt_nxt;
   logic [GAIN_WIDTH-1:0] w_eff;
   logic [GAIN_WIDTH-1:0] w_dist;
   logic [GAIN_WIDTH-1:0] w_step;
   logic                  w_up;
   logic                  w_accept;
   logic                  w_mute_act;

`ifdef GAIN_RAMP_SOFT_MUTE_EN
   assign w_mute_act = i_mute;
`else
   logic w_unused_mute;
   assign w_unused_mute = i_mute;
   assign w_mute_act    = 1'b0;
`endif

   assign w_eff = w_mute_act ? '0 : r_tgt;

   // Clamp the final step so the gain lands exactly on the target and never wraps.
   always_comb begin
      w_up   = 1'b0;
      w_dist = '0;
      w_step = r_cur;
      w_up   = (w_eff > r_cur);
      w_dist = w_up ? (w_eff - r_cur) : (r_cur - w_eff);
      if (w_dist <= C_STEP) begin
         w_step = w_eff;
      end else if (w_up) begin
         w_step = r_cur + C_STEP;
      end else begin
         w_step = r_cur - C_STEP;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur;
      w_tgt_nxt   = r_tgt;
      w_accept    = i_set_valid & r_set_ready;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_tgt_nxt = i_set_gain;
            end
            if (w_mute_act) begin
               if (r_cur != '0) begin
                  w_state_nxt = S_RAMP;
               end
`ifdef GAIN_RAMP_SOFT_MUTE_EN
               else begin
                  w_state_nxt = S_MUTED;
               end
`endif
            end else if (w_accept && (i_set_gain != r_cur)) begin
               w_state_nxt = S_RAMP;
            end
         end
         S_RAMP: begin
            if (i_sample_tick) begin
               w_cur_nxt = w_step;
               if (w_step == w_eff) begin
`ifdef GAIN_RAMP_SOFT_MUTE_EN
                  w_state_nxt = w_mute_act ? S_MUTED : S_IDLE;
`else
                  w_state_nxt = S_IDLE;
`endif
               end
            end
         end
`ifdef GAIN_RAMP_SOFT_MUTE_EN
         S_MUTED: begin
            w_cur_nxt = '0;
            if (w_accept) begin
               w_tgt_nxt = i_set_gain;
            end
            if (!w_mute_act) begin
               w_state_nxt = (w_tgt_nxt != '0) ? S_RAMP : S_IDLE;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Ready/busy are registered from the next state so they switch on the same edge as the gain.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cur        <= C_DEFAULT;
         r_tgt        <= C_DEFAULT;
         r_pipe_valid <= 1'b0;
         r_set_ready  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cur        <= w_cur_nxt;
         r_tgt        <= w_tgt_nxt;
         r_pipe_valid <= i_sample_tick;
         r_set_ready  <= (w_state_nxt != S_RAMP);
         r_busy       <= (w_state_nxt == S_RAMP);
      end
   end

   assign o_gain_value = r_cur;
   assign o_pipe_valid = r_pipe_valid;
   assign o_set_ready  = r_set_ready;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Bench for gain_ramp_ctrl: three instances (step 1, 4, 5) checked every cycle against a
// target-distance model, plus hand-computed gain sequences for each directed scenario.
module tb_gain_ramp_ctrl;
   localparam int W   = 11;
   localparam int DEF = 16;
`ifdef GAIN_RAMP_SOFT_MUTE_EN
   localparam bit MUTE_EN = 1'b1;
`else
   localparam bit MUTE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_v[3];
   logic         sv[3];
   logic [W-1:0] sg[3];
   logic         mute_v[3];
   logic         man_tick;
   logic         auto_tick;
   logic         tick_en;
   logic         tick;
   logic [W-1:0] gv[3];
   logic         rdy[3];
   logic         bsy[3];
   logic         pv[3];

   assign tick = tick_en ? auto_tick : man_tick;

   gain_ramp_ctrl #(.GAIN_WIDTH(W), .DEFAULT_GAIN(DEF), .RAMP_STEP(1)) u0 (
      .i_clk(clk), .i_rst(rst_v[0]), .i_sample_tick(tick), .i_set_valid(sv[0]),
      .i_set_gain(sg[0]), .o_set_ready(rdy[0]), .i_mute(mute_v[0]),
      .o_gain_value(gv[0]), .o_pipe_valid(pv[0]), .o_busy(bsy[0]));
   gain_ramp_ctrl #(.GAIN_WIDTH(W), .DEFAULT_GAIN(DEF), .RAMP_STEP(4)) u1 (
      .i_clk(clk), .i_rst(rst_v[1]), .i_sample_tick(tick), .i_set_valid(sv[1]),
      .i_set_gain(sg[1]), .o_set_ready(rdy[1]), .i_mute(mute_v[1]),
      .o_gain_value(gv[1]), .o_pipe_valid(pv[1]), .o_busy(bsy[1]));
   gain_ramp_ctrl #(.GAIN_WIDTH(W), .DEFAULT_GAIN(DEF), .RAMP_STEP(5)) u2 (
      .i_clk(clk), .i_rst(rst_v[2]), .i_sample_tick(tick), .i_set_valid(sv[2]),
      .i_set_gain(sg[2]), .o_set_ready(rdy[2]), .i_mute(mute_v[2]),
      .o_gain_value(gv[2]), .o_pipe_valid(pv[2]), .o_busy(bsy[2]));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0d expected=%0d", nm, k, act, exp);
      end
   endtask

   // Model: the gain moves toward the effective target on ticks while a ramp is pending;
   // busy simply means "applied gain differs from effective target".
   int steps[3];
   int m_cur[3], m_tgt[3];
   bit m_busy[3], m_rdy[3], m_pv[3];
   int n_cur[3], n_tgt[3], n_eff[3];

   function automatic int approach(input int c, input int e, input int s);
      int d;
      d = (e > c) ? e - c : c - e;
      if (d <= s) return e;
      return (e > c) ? c + s : c - s;
   endfunction

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         n_tgt[k] = (sv[k] && m_rdy[k]) ? int'(sg[k]) : m_tgt[k];
         n_eff[k] = (MUTE_EN && mute_v[k]) ? 0 : n_tgt[k];
         n_cur[k] = (tick && m_busy[k]) ? approach(m_cur[k], n_eff[k], steps[k]) : m_cur[k];
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst_v[k]) begin
            m_cur[k]  <= DEF;
            m_tgt[k]  <= DEF;
            m_busy[k] <= 1'b0;
            m_rdy[k]  <= 1'b0;
            m_pv[k]   <= 1'b0;
         end else begin
            m_cur[k]  <= n_cur[k];
            m_tgt[k]  <= n_tgt[k];
            m_busy[k] <= (n_cur[k] != n_eff[k]);
            m_rdy[k]  <= (n_cur[k] == n_eff[k]);
            m_pv[k]   <= tick;
         end
      end
   end

   bit cmp_en = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
               chk("gain_value", k, 32'(gv[k]), 32'(m_cur[k]));
               chk("pipe_valid", k, 32'(pv[k]), 32'(m_pv[k]));
               chk("busy", k, 32'(bsy[k]), 32'(m_busy[k]));
               chk("set_ready", k, 32'(rdy[k]), 32'(m_rdy[k]));
            end
         end
      end
   end

   // Records every change of the monitored instance's gain, with busy/ready at that edge.
   int           mon_k = 0;
   int           chg[$];
   bit           chg_busy[$];
   bit           chg_rdy[$];
   logic [W-1:0] prev_g;
   initial begin
      forever begin
         @(negedge clk);
         if (gv[mon_k] !== prev_g) begin
            chg.push_back(int'(gv[mon_k]));
            chg_busy.push_back(bsy[mon_k]);
            chg_rdy.push_back(rdy[mon_k]);
            prev_g = gv[mon_k];
         end
      end
   end

   int tper = 8;
   int tcnt = 0;
   initial begin
      auto_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_en) begin
            tcnt      = (tcnt + 1) % tper;
            auto_tick = (tcnt == 0);
         end else begin
            tcnt      = 0;
            auto_tick = 1'b0;
         end
      end
   end

   task automatic clear_mon(input int k);
      mon_k  = k;
      prev_g = gv[k];
      chg.delete();
      chg_busy.delete();
      chg_rdy.delete();
   endtask

   task automatic chk_chg(input string nm, input int i, input int exp);
      int act;
      act = (i < chg.size()) ? chg[i] : -1;
      chk(nm, i, 32'(act), 32'(exp));
   endtask

   task automatic do_reset();
      for (int k = 0; k < 3; k++) begin
         rst_v[k]  = 1'b1;
         sv[k]     = 1'b0;
         mute_v[k] = 1'b0;
      end
      @(negedge clk);
      cmp_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_gain", k, 32'(gv[k]), 32'd16);
         chk("rst_pipe_valid", k, 32'(pv[k]), 32'd0);
         chk("rst_busy", k, 32'(bsy[k]), 32'd0);
         chk("rst_set_ready", k, 32'(rdy[k]), 32'd0);
         rst_v[k] = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("ready_after_rst", k, 32'(rdy[k]), 32'd1);
   endtask

   task automatic send(input int k, input int g);
      bit done;
      done  = 1'b0;
      sv[k] = 1'b1;
      sg[k] = g[W-1:0];
      for (int n = 0; n < 600 && !done; n++) begin
         done = rdy[k];
         @(negedge clk);
      end
      sv[k] = 1'b0;
      chk("handshake_accepted", k, 32'(done), 32'd1);
   endtask

   task automatic wait_idle(input int k, input int lim);
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while (m_busy[k] && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("ramp_finished", k, 32'(m_busy[k]), 32'd0);
   endtask

   task automatic pulse();
      man_tick = 1'b1;
      @(negedge clk);
      man_tick = 1'b0;
   endtask

   int exp_a[14] = '{17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30};
   int exp_b[3]  = '{12, 8, 5};
   int exp_c[5]  = '{21, 26, 31, 36, 40};

   initial begin
      steps[0] = 1;
      steps[1] = 4;
      steps[2] = 5;
      man_tick = 1'b0;
      tick_en  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rst_v[k]  = 1'b1;
         sv[k]     = 1'b0;
         sg[k]     = '0;
         mute_v[k] = 1'b0;
      end
      do_reset();

      // Upward ramp to 20, with a 30 request held while the ramp is still running.
      clear_mon(0);
      tper    = 8;
      tick_en = 1'b1;
      send(0, 20);
      repeat (10) @(negedge clk);
      send(0, 30);
      wait_idle(0, 400);
      chk("up_seq_len", 0, 32'(chg.size()), 32'd14);
      for (int i = 0; i < 14; i++) chk_chg("up_seq", i, exp_a[i]);
      if (chg.size() >= 4) begin
         chk("busy_at_19", 0, 32'(chg_busy[2]), 32'd1);
         chk("busy_at_20", 0, 32'(chg_busy[3]), 32'd0);
         chk("ready_at_20", 0, 32'(chg_rdy[3]), 32'd1);
      end

      // Downward ramp with clamp on the last step (step 4), and upward clamp (step 5).
      do_reset();
      clear_mon(1);
      send(1, 5);
      wait_idle(1, 200);
      chk("down_seq_len", 1, 32'(chg.size()), 32'd3);
      for (int i = 0; i < 3; i++) chk_chg("down_seq", i, exp_b[i]);
      clear_mon(2);
      send(2, 40);
      wait_idle(2, 200);
      chk("up5_seq_len", 2, 32'(chg.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk_chg("up5_seq", i, exp_c[i]);

      // Tick coincident with acceptance takes no step.
      tick_en = 1'b0;
      @(negedge clk);
      sv[1]    = 1'b1;
      sg[1]    = 11'd13;
      man_tick = 1'b1;
      @(negedge clk);
      sv[1]    = 1'b0;
      man_tick = 1'b0;
      chk("coinc_gain", 1, 32'(gv[1]), 32'd5);
      chk("coinc_busy", 1, 32'(bsy[1]), 32'd1);
      chk("coinc_ready", 1, 32'(rdy[1]), 32'd0);
      repeat (3) @(negedge clk);
      chk("coinc_hold", 1, 32'(gv[1]), 32'd5);
      pulse();
      chk("coinc_step1", 1, 32'(gv[1]), 32'd9);
      pulse();
      chk("coinc_step2", 1, 32'(gv[1]), 32'd13);
      chk("coinc_end_busy", 1, 32'(bsy[1]), 32'd0);

      // Reset in the middle of a 16 -> 40 ramp, coincident with a tick.
      do_reset();
      clear_mon(0);
      send(0, 40);
      pulse();
      pulse();
      chk("pre_rst_gain", 0, 32'(gv[0]), 32'd18);
      rst_v[0] = 1'b1;
      man_tick = 1'b1;
      @(negedge clk);
      chk("midrst_gain", 0, 32'(gv[0]), 32'd16);
      chk("midrst_busy", 0, 32'(bsy[0]), 32'd0);
      chk("midrst_pipe_valid", 0, 32'(pv[0]), 32'd0);
      rst_v[0] = 1'b0;
      man_tick = 1'b0;
      @(negedge clk);
      repeat (3) pulse();
      chk("post_rst_gain", 0, 32'(gv[0]), 32'd16);
      chk("post_rst_changes", 0, 32'(chg.size()), 32'd3);

      // Full-scale ramp up and back to zero with step 5: no wrap at either end.
      do_reset();
      clear_mon(2);
      tper    = 2;
      tick_en = 1'b1;
      send(2, 2047);
      wait_idle(2, 3000);
      chk("top_len", 2, 32'(chg.size()), 32'd407);
      chk_chg("top_prelast", 405, 2046);
      chk_chg("top_last", 406, 2047);
      clear_mon(2);
      send(2, 0);
      wait_idle(2, 3000);
      chk("bottom_len", 2, 32'(chg.size()), 32'd410);
      chk_chg("bottom_prelast", 408, 2);
      chk_chg("bottom_last", 409, 0);

`ifdef GAIN_RAMP_SOFT_MUTE_EN
      // Soft mute: ramp 20 -> 0, latch a target while muted, resume on release.
      do_reset();
      tper = 8;
      send(2, 20);
      wait_idle(2, 200);
      clear_mon(2);
      mute_v[2] = 1'b1;
      wait_idle(2, 200);
      chk("mute_len", 2, 32'(chg.size()), 32'd4);
      chk_chg("mute_seq", 0, 15);
      chk_chg("mute_seq", 1, 10);
      chk_chg("mute_seq", 2, 5);
      chk_chg("mute_seq", 3, 0);
      chk("muted_ready", 2, 32'(rdy[2]), 32'd1);
      chk("muted_busy", 2, 32'(bsy[2]), 32'd0);
      send(2, 10);
      repeat (20) @(negedge clk);
      chk("muted_hold", 2, 32'(gv[2]), 32'd0);
      mute_v[2] = 1'b0;
      wait_idle(2, 200);
      chk("unmute_len", 2, 32'(chg.size()), 32'd6);
      chk_chg("unmute_seq", 4, 5);
      chk_chg("unmute_seq", 5, 10);
`endif

      tick_en = 1'b0;
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog[0] got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
